// File: rtl/bcd_adder_scan.sv
// Multi-digit BCD adder (one digit per clock, registered ripple carry) with a scanned 7-segment display.
// Optional macro BLANK_LEADING_ZERO_EN blanks display digits above the most significant non-zero digit.
module bcd_adder_scan #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a_bcd,
  input  logic [4*DIGITS-1:0]   b_bcd,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum_bcd,
  output logic                  carry_out,
  output logic                  err,
  output logic [DIGITS-1:0]     dig,
  output logic [6:0]            seg
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    aOp_q, aOp_d, bOp_q, bOp_d;
  logic [W-1:0]    work_q, work_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            errAcc_q, errAcc_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            err_q, err_d;

  logic [CW-1:0]     scanCnt_q, scanCnt_d;
  logic [IW-1:0]     scanIdx_q, scanIdx_d;
  logic [DIGITS-1:0] dig_q, dig_d;
  logic [6:0]        seg_q, seg_d;

  logic [3:0] aDig, bDig, digOut, selDigit;
  logic [4:0] raw;
  logic       cNext, digErr, blank;
  logic [W-1:0] newWork;

  function automatic logic [6:0] segDecode(input logic [3:0] d);
    case (d)
      4'h0: segDecode = 7'b0000001;
      4'h1: segDecode = 7'b1001111;
      4'h2: segDecode = 7'b0010010;
      4'h3: segDecode = 7'b0000110;
      4'h4: segDecode = 7'b1001100;
      4'h5: segDecode = 7'b0100100;
      4'h6: segDecode = 7'b0100000;
      4'h7: segDecode = 7'b0001111;
      4'h8: segDecode = 7'b0000000;
      4'h9: segDecode = 7'b0000100;
      4'hA: segDecode = 7'b0001000;
      4'hB: segDecode = 7'b1100000;
      4'hC: segDecode = 7'b0110001;
      4'hD: segDecode = 7'b1000010;
      4'hE: segDecode = 7'b0110000;
      default: segDecode = 7'b0111000;
    endcase
  endfunction

  // Operands shift right each ADD cycle, so the current digit is always the low nibble.
  always_comb begin
    aDig    = aOp_q[3:0];
    bDig    = bOp_q[3:0];
    raw     = {1'b0, aDig} + {1'b0, bDig} + {4'b0000, carry_q};
    cNext   = (raw >= 5'd10);
    digOut  = cNext ? (raw[3:0] - 4'd10) : raw[3:0];
    digErr  = (aDig > 4'd9) || (bDig > 4'd9);
    newWork = (work_q >> 4) | (W'(digOut) << (W - 4));
  end

  always_comb begin
    state_d  = state_q;
    aOp_d    = aOp_q;
    bOp_d    = bOp_q;
    work_d   = work_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    errAcc_d = errAcc_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          aOp_d    = a_bcd;
          bOp_d    = b_bcd;
          work_d   = '0;
          idx_d    = '0;
          carry_d  = 1'b0;
          errAcc_d = 1'b0;
          state_d  = ADD;
        end
      end
      ADD: begin
        aOp_d    = aOp_q >> 4;
        bOp_d    = bOp_q >> 4;
        work_d   = newWork;
        carry_d  = cNext;
        errAcc_d = errAcc_q | digErr;
        idx_d    = idx_q + IW'(1);
        // Results are latched on the edge into DONE so they are valid while done is high.
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          if (errAcc_q | digErr) begin
            sum_d  = '0;
            cout_d = 1'b0;
            err_d  = 1'b1;
          end else begin
            sum_d  = newWork;
            cout_d = cNext;
            err_d  = 1'b0;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // dig and seg are both derived from the next scan index so they update together.
  always_comb begin
    scanCnt_d = scanCnt_q + CW'(1);
    scanIdx_d = scanIdx_q;
    if (scanCnt_q == LAST_CNT) begin
      scanCnt_d = '0;
      scanIdx_d = (scanIdx_q == LAST_IDX) ? '0 : scanIdx_q + IW'(1);
    end
    selDigit = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      if (scanIdx_d == IW'(i)) selDigit = sum_d[4*i +: 4];
    end
`ifdef BLANK_LEADING_ZERO_EN
    blank = (scanIdx_d != '0) && ((sum_d >> {scanIdx_d, 2'b00}) == '0);
`else
    blank = 1'b0;
`endif
    dig_d = DIGITS'(1) << scanIdx_d;
    if (err_d)      seg_d = 7'b0110000;
    else if (blank) seg_d = 7'b1111111;
    else            seg_d = segDecode(selDigit);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      aOp_q     <= '0;
      bOp_q     <= '0;
      work_q    <= '0;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      errAcc_q  <= 1'b0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      err_q     <= 1'b0;
      scanCnt_q <= '0;
      scanIdx_q <= '0;
      dig_q     <= DIGITS'(1);
      seg_q     <= 7'b0000001;
    end else begin
      state_q   <= state_d;
      aOp_q     <= aOp_d;
      bOp_q     <= bOp_d;
      work_q    <= work_d;
      idx_q     <= idx_d;
      carry_q   <= carry_d;
      errAcc_q  <= errAcc_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      err_q     <= err_d;
      scanCnt_q <= scanCnt_d;
      scanIdx_q <= scanIdx_d;
      dig_q     <= dig_d;
      seg_q     <= seg_d;
    end
  end

  assign busy      = (state_q == ADD);
  assign done      = (state_q == DONE);
  assign sum_bcd   = sum_q;
  assign carry_out = cout_q;
  assign err       = err_q;
  assign dig       = dig_q;
  assign seg       = seg_q;

endmodule

// File: tb/tb_bcd_adder_scan.sv
// Directed, table-driven bench for bcd_adder_scan with DIGITS=4 and a short scan period.
// Display expectations follow BLANK_LEADING_ZERO_EN when it is defined for the build.
module tb_bcd_adder_scan;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a_bcd = '0;
  logic [15:0] b_bcd = '0;
  logic        busy, done, carry_out, err;
  logic [15:0] sum_bcd;
  logic [3:0]  dig;
  logic [6:0]  seg;

  int checks = 0;
  int failures = 0;

  bcd_adder_scan #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_bcd(a_bcd), .b_bcd(b_bcd),
    .busy(busy), .done(done), .sum_bcd(sum_bcd), .carry_out(carry_out),
    .err(err), .dig(dig), .seg(seg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] s;
    logic        c;
    logic        e;
    logic        scan;
  } vec_t;

  vec_t vecs[10];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Hand-written segment table, active low {a..g}.
  function automatic logic [6:0] expSeg(input logic [15:0] s, input logic e, input int idx);
    logic [15:0] sh;
    sh = s >> (4 * idx);
    if (e) return 7'b0110000;
`ifdef BLANK_LEADING_ZERO_EN
    if (idx > 0 && sh == 16'h0) return 7'b1111111;
`endif
    case (sh[3:0])
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0000100;
      default: return 7'bxxxxxxx;
    endcase
  endfunction

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    a_bcd = a;
    b_bcd = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a_bcd = 16'hFFFF;
    b_bcd = 16'hFFFF;
  endtask

  task automatic runVector(input vec_t v);
    logic busyOk;
    applyStimulus(v.a, v.b);
    busyOk = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      @(negedge clk);
      if (!(busy === 1'b1 && done === 1'b0)) busyOk = 1'b0;
    end
    checkOutput("busyWindow", busyOk, 1'b1);
    @(negedge clk);
    checkOutput("donePulse", done, 1'b1);
    checkOutput("busyInDone", busy, 1'b0);
    checkOutput("sum", sum_bcd, v.s);
    checkOutput("carry", carry_out, v.c);
    checkOutput("err", err, v.e);
    @(negedge clk);
    checkOutput("doneEnd", done, 1'b0);
  endtask

  task automatic checkScan(input logic [15:0] s, input logic e);
    logic [3:0] seen;
    int idx;
    seen = '0;
    for (int n = 0; n < 4 * SCAN_DIV; n++) begin
      @(negedge clk);
      checkOutput("scanOneHot", (dig != 0) && ((dig & (dig - 4'd1)) == 0), 1'b1);
      idx = 0;
      for (int k = 0; k < DIGITS; k++) if (dig[k]) idx = k;
      checkOutput($sformatf("scanSeg%0d", idx), seg, expSeg(s, e, idx));
      seen |= dig;
    end
    checkOutput("scanCover", seen, 4'hF);
  endtask

  initial begin
    logic ok;
    vecs[0] = '{16'h1234, 16'h5678, 16'h6912, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{16'h12A4, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{16'h0005, 16'h0004, 16'h0009, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{16'h4999, 16'h5001, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{16'h0019, 16'h0023, 16'h0042, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{16'h0001, 16'hF000, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{16'h8765, 16'h4321, 16'h3086, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[9] = '{16'h0500, 16'h0407, 16'h0907, 1'b0, 1'b0, 1'b0};

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstBusy", busy, 1'b0);
    checkOutput("rstDone", done, 1'b0);
    checkOutput("rstSum", sum_bcd, 16'h0);
    checkOutput("rstCarry", carry_out, 1'b0);
    checkOutput("rstErr", err, 1'b0);
    checkOutput("rstDig", dig, 4'b0001);
    checkOutput("rstSeg", seg, 7'b0000001);

    // Scan timing straight out of reset: index advances every SCAN_DIV edges
    rst_n = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      checkOutput($sformatf("scanDig%0d", n), dig, 4'b0001 << ((n / SCAN_DIV) % DIGITS));
      checkOutput($sformatf("scanRstSeg%0d", n), seg, expSeg(16'h0, 1'b0, (n / SCAN_DIV) % DIGITS));
    end

    for (int i = 0; i < 10; i++) begin
      $display("[TB] vector %0d: %h + %h", i, vecs[i].a, vecs[i].b);
      runVector(vecs[i]);
      if (vecs[i].scan) checkScan(vecs[i].s, vecs[i].e);
    end

    // Second start during ADD is ignored and not queued
    applyStimulus(16'h1234, 16'h5678);
    start = 1'b1;
    a_bcd = 16'h0001;
    b_bcd = 16'h0001;
    @(negedge clk);
    checkOutput("ignBusy1", busy, 1'b1);
    @(posedge clk);
    #1;
    start = 1'b0;
    ok = 1'b1;
    for (int n = 2; n <= 4; n++) begin
      @(negedge clk);
      if (busy !== 1'b1 || done !== 1'b0) ok = 1'b0;
    end
    checkOutput("ignBusyWindow", ok, 1'b1);
    @(negedge clk);
    checkOutput("ignDone", done, 1'b1);
    checkOutput("ignSum", sum_bcd, 16'h6912);
    ok = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) ok = 1'b0;
    end
    checkOutput("ignNoQueue", ok, 1'b1);

    // Reset mid-ADD aborts without a done pulse
    applyStimulus(16'h0005, 16'h0004);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("abortSum", sum_bcd, 16'h0);
    checkOutput("abortBusy", busy, 1'b0);
    rst_n = 1'b1;
    ok = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || sum_bcd !== 16'h0 || carry_out !== 1'b0 || err !== 1'b0) ok = 1'b0;
    end
    checkOutput("abortQuiet", ok, 1'b1);
    runVector(vecs[3]);

    // Holding start restarts every DIGITS+2 cycles
    @(negedge clk);
    a_bcd = 16'h0001;
    b_bcd = 16'h0002;
    start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 18; n++) begin
      @(negedge clk);
      checkOutput($sformatf("holdDone%0d", n), done, (n % (DIGITS + 2)) == 5);
    end
    start = 1'b0;
    checkOutput("holdSum", sum_bcd, 16'h0003);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
